// File: rtl/morse_pkg.sv
// Shared symbol encodings, ASCII constants and the International Morse code table
// used by the Morse character decoder and its lookup.
package morse_pkg;

    localparam logic [1:0] SYM_WORD = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_CHAR = 2'b11;

    localparam logic [7:0] ASCII_SPACE      = 8'h20;
    localparam logic [7:0] ERR_CHAR_DEFAULT = 8'h3F;

    // code is right-aligned, first symbol in the MSB of the used bits, dash = 1
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] code;
        logic [7:0] ascii;
    } morse_entry_t;

    localparam int MORSE_N = 36;

    localparam morse_entry_t MORSE_TABLE [MORSE_N] = '{
        '{3'd2, 5'b00001, 8'h41}, '{3'd4, 5'b01000, 8'h42}, '{3'd4, 5'b01010, 8'h43},
        '{3'd3, 5'b00100, 8'h44}, '{3'd1, 5'b00000, 8'h45}, '{3'd4, 5'b00010, 8'h46},
        '{3'd3, 5'b00110, 8'h47}, '{3'd4, 5'b00000, 8'h48}, '{3'd2, 5'b00000, 8'h49},
        '{3'd4, 5'b00111, 8'h4A}, '{3'd3, 5'b00101, 8'h4B}, '{3'd4, 5'b00100, 8'h4C},
        '{3'd2, 5'b00011, 8'h4D}, '{3'd2, 5'b00010, 8'h4E}, '{3'd3, 5'b00111, 8'h4F},
        '{3'd4, 5'b00110, 8'h50}, '{3'd4, 5'b01101, 8'h51}, '{3'd3, 5'b00010, 8'h52},
        '{3'd3, 5'b00000, 8'h53}, '{3'd1, 5'b00001, 8'h54}, '{3'd3, 5'b00001, 8'h55},
        '{3'd4, 5'b00001, 8'h56}, '{3'd3, 5'b00011, 8'h57}, '{3'd4, 5'b01001, 8'h58},
        '{3'd4, 5'b01011, 8'h59}, '{3'd4, 5'b01100, 8'h5A},
        '{3'd5, 5'b11111, 8'h30}, '{3'd5, 5'b01111, 8'h31}, '{3'd5, 5'b00111, 8'h32},
        '{3'd5, 5'b00011, 8'h33}, '{3'd5, 5'b00001, 8'h34}, '{3'd5, 5'b00000, 8'h35},
        '{3'd5, 5'b10000, 8'h36}, '{3'd5, 5'b11000, 8'h37}, '{3'd5, 5'b11100, 8'h38},
        '{3'd5, 5'b11110, 8'h39}
    };

endpackage

// File: rtl/morse_symbol_decoder_lut.sv
// Combinational Morse lookup: (pattern, length) -> {hit, uppercase ASCII}.
module morse_symbol_decoder_lut
    import morse_pkg::*;
#(
    parameter int MAX_LEN = 5,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               hit,
    output logic [7:0]         ascii
);

    // Patterns are unique per (len, code) and bits above len are always zero,
    // so a plain equality match on the whole register is exact.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hit   = 1'b0;
        ascii = 8'h00;
        for (int i = 0; i < MORSE_N; i++) begin
            if (len == LEN_W'(MORSE_TABLE[i].len) &&
                pat == MAX_LEN'(MORSE_TABLE[i].code)) begin
                hit   = 1'b1;
                ascii = MORSE_TABLE[i].ascii;
            end
        end
    end

endmodule

// File: rtl/morse_symbol_decoder.sv
// Morse character decoder: accumulates dot/dash symbols, decodes on gaps, inserts
// word spaces and buffers results in a small output FIFO with back-pressure.
module morse_symbol_decoder
    import morse_pkg::*;
#(
    parameter int         MAX_LEN  = 5,
    parameter int         DEPTH    = 4,
    parameter logic [7:0] ERR_CHAR = ERR_CHAR_DEFAULT,
    parameter bit         LOWER    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    input  logic [1:0] sym,
    output logic       sym_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_char,
    output logic [7:0] err_cnt,
    output logic       busy
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovf;
    logic               pending_space;
    logic               last_space;
    logic               emitted;

    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    logic       fifo_full;
    logic       accept;
    logic       pop;
    logic       push;
    logic [7:0] push_data;
    logic       err_push;
    logic       lut_hit;
    logic [7:0] lut_ascii;
    logic       char_bad;
    logic [7:0] char_code;

    morse_symbol_decoder_lut #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_lut (
        .pat   (pat),
        .len   (len),
        .hit   (lut_hit),
        .ascii (lut_ascii)
    );

    always_comb begin
        fifo_full = (count == (PTR_W + 1)'(DEPTH));
        sym_ready = !fifo_full && !pending_space;
        accept    = sym_valid && sym_ready;
        out_valid = (count != '0);
        pop       = out_valid && out_ready;
        busy      = (len != '0) || pending_space;
        char_bad  = ovf || !lut_hit;

        if (char_bad)
            char_code = ERR_CHAR;
        else if (LOWER && lut_ascii >= 8'h41 && lut_ascii <= 8'h5A)
            char_code = lut_ascii | 8'h20;
        else
            char_code = lut_ascii;

        // At most one push per cycle: the deferred space never coincides with an
        // accepted symbol because pending_space holds sym_ready low.
        push      = 1'b0;
        push_data = char_code;
        err_push  = 1'b0;
        if (pending_space && !fifo_full) begin
            push      = 1'b1;
            push_data = ASCII_SPACE;
        end else if (accept && (sym == SYM_CHAR || sym == SYM_WORD)) begin
            if (len != '0) begin
                push     = 1'b1;
                err_push = char_bad;
            end else if (sym == SYM_WORD && !last_space && emitted) begin
                push      = 1'b1;
                push_data = ASCII_SPACE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            pat           <= '0;
            len           <= '0;
            ovf           <= 1'b0;
            pending_space <= 1'b0;
            last_space    <= 1'b0;
            emitted       <= 1'b0;
            err_cnt       <= 8'h00;
        end else begin
            if (pending_space && !fifo_full) begin
                pending_space <= 1'b0;
                last_space    <= 1'b1;
            end else if (accept) begin
                case (sym)
                    SYM_DOT, SYM_DASH: begin
                        if (len < LEN_W'(MAX_LEN)) begin
                            pat <= {pat[MAX_LEN-2:0], sym == SYM_DASH};
                            len <= len + LEN_W'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                    default: begin
                        if (len != '0) begin
                            pat           <= '0;
                            len           <= '0;
                            ovf           <= 1'b0;
                            last_space    <= 1'b0;
                            emitted       <= 1'b1;
                            pending_space <= (sym == SYM_WORD);
                        end else if (push) begin
                            last_space <= 1'b1;
                        end
                    end
                endcase
            end

            if (err_push && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'h01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; entries are only visible once written,
    // and out_char is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign out_char = out_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Scoreboard bench for morse_symbol_decoder: an uppercase and a lowercase instance
// share stimulus; expected characters are queued per instance and checked on pop.
module tb_morse_symbol_decoder;

    localparam logic [1:0] S_WORD = 2'b00;
    localparam logic [1:0] S_DOT  = 2'b01;
    localparam logic [1:0] S_DASH = 2'b10;
    localparam logic [1:0] S_CHAR = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sym_valid;
    logic [1:0] sym;
    logic       out_ready;

    logic       sym_ready,  out_valid,  busy;
    logic [7:0] out_char,   err_cnt;
    logic       sym_ready_l, out_valid_l, busy_l;
    logic [7:0] out_char_l,  err_cnt_l;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] exp_q   [$];
    logic [7:0] exp_l_q [$];

    always #5 clk = ~clk;

    morse_symbol_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_valid (sym_valid),
        .sym       (sym),
        .sym_ready (sym_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    morse_symbol_decoder #(.LOWER(1'b1)) dut_lower (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_valid (sym_valid),
        .sym       (sym),
        .sym_ready (sym_ready_l),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .out_char  (out_char_l),
        .err_cnt   (err_cnt_l),
        .busy      (busy_l)
    );

    // Output monitors: every pop is matched against the head of its queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_upper: unexpected char %h, nothing expected", out_char);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_char !== e) begin
                    miscompares++;
                    $display("FAIL pop_upper: got %h expected %h", out_char, e);
                end
            end
        end
        if (rst_n && out_valid_l && out_ready) begin
            vectors++;
            if (exp_l_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_lower: unexpected char %h, nothing expected", out_char_l);
            end else begin
                logic [7:0] e;
                e = exp_l_q.pop_front();
                if (out_char_l !== e) begin
                    miscompares++;
                    $display("FAIL pop_lower: got %h expected %h", out_char_l, e);
                end
            end
        end
    end

    task automatic expect_char(input logic [7:0] upper, input logic [7:0] lower);
        exp_q.push_back(upper);
        exp_l_q.push_back(lower);
    endtask

    task automatic send_sym(input logic [1:0] s);
        int budget = 200;
        sym_valid = 1'b1;
        sym       = s;
        while (!sym_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("FAIL send_timeout: sym_ready stayed %b expected 1", sym_ready);
        end
        @(posedge clk); #1;
        sym_valid = 1'b0;
    endtask

    task automatic send_code(input string code);
        for (int i = 0; i < code.len(); i++)
            send_sym(code[i] == "-" ? S_DASH : S_DOT);
    endtask

    task automatic wait_drain();
        int budget = 100;
        while ((exp_q.size() != 0 || exp_l_q.size() != 0) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d/%0d entries left expected 0",
                     exp_q.size(), exp_l_q.size());
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        check_bit ("reset_sym_ready", sym_ready, 1'b1);
        check_bit ("reset_out_valid", out_valid, 1'b0);
        check_byte("reset_out_char",  out_char,  8'h00);
        check_byte("reset_err_cnt",   err_cnt,   8'h00);
        check_bit ("reset_busy",      busy,      1'b0);
        check_bit ("reset_busy_l",    busy_l,    1'b0);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        expect_char(8'h41, 8'h61);
        send_code(".-");
        send_sym(S_CHAR);
        check_bit ("a_latency_valid", out_valid, 1'b1);
        check_byte("a_latency_char",  out_char,  8'h41);
        check_byte("a_err_cnt",       err_cnt,   8'h00);
        wait_drain();

        expect_char(8'h30, 8'h30);
        send_code("-----");
        send_sym(S_CHAR);
        expect_char(8'h43, 8'h63);
        send_code("-.-.");
        send_sym(S_CHAR);
        wait_drain();
    endtask

    task automatic test_errors();
        expect_char(8'h3F, 8'h3F);
        send_code("......");
        send_sym(S_CHAR);
        check_byte("ovf_err_cnt",   err_cnt,   8'h01);
        check_byte("ovf_err_cnt_l", err_cnt_l, 8'h01);
        expect_char(8'h3F, 8'h3F);
        send_code("..--");
        send_sym(S_CHAR);
        check_byte("nomatch_err_cnt", err_cnt, 8'h02);
        wait_drain();
    endtask

    task automatic test_word_gap();
        expect_char(8'h53, 8'h73);
        expect_char(8'h20, 8'h20);
        send_code("...");
        send_sym(S_WORD);
        check_bit("word_pending_blocks", sym_ready, 1'b0);
        check_bit("word_pending_busy",   busy,      1'b1);
        @(posedge clk); #1;
        check_bit("word_ready_back",     sym_ready, 1'b1);
        send_sym(S_WORD);
        repeat (5) @(posedge clk);
        #1;
        wait_drain();
        check_bit("word_idle_busy", busy, 1'b0);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        expect_char(8'h45, 8'h65);
        send_code(".");
        send_sym(S_CHAR);
        expect_char(8'h54, 8'h74);
        send_code("-");
        send_sym(S_CHAR);
        expect_char(8'h45, 8'h65);
        send_code(".");
        send_sym(S_CHAR);
        expect_char(8'h54, 8'h74);
        send_code("-");
        send_sym(S_CHAR);
        check_bit("full_sym_ready", sym_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_bit ("stall_valid", out_valid, 1'b1);
        check_byte("stall_char",  out_char,  8'h45);
        out_ready = 1'b1;
        wait_drain();
        check_bit("drained_sym_ready", sym_ready, 1'b1);
    endtask

    task automatic test_reset_mid_char();
        send_code(".-");
        check_bit("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #3;
        check_bit("mid_rst_busy",      busy,      1'b0);
        check_bit("mid_rst_out_valid", out_valid, 1'b0);
        check_bit("mid_rst_sym_ready", sym_ready, 1'b1);
        check_byte("mid_rst_err_cnt",  err_cnt,   8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_bit("post_rst_no_output", out_valid, 1'b0);
        expect_char(8'h45, 8'h65);
        send_code(".");
        send_sym(S_CHAR);
        wait_drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        sym_valid = 1'b0;
        sym       = S_WORD;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_errors();
        test_word_gap();
        test_back_to_back();
        test_reset_mid_char();
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
